// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard unit with a long-latency scoreboard for the Execute stage.
// Optional FWD_STALL_CNT_EN adds a saturating stall counter and per-cause stall bits.
module fwd_hazard_scoreboard #(
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic [NUM_RD*5-1:0]       i_RsAddr_E,
  input  logic [NUM_RD-1:0]         i_RsUsed_E,
  input  logic [NUM_STG*5-1:0]      i_StgRdAddr,
  input  logic [NUM_STG-1:0]        i_StgRegWrEn,
  input  logic [NUM_STG-1:0]        i_StgRdValid,
  input  logic [4:0]                i_RS2Addr_M,
  input  logic                      i_IssueValid_E,
  input  logic                      i_Flush_E,
  input  logic [4:0]                i_IssueRd_E,
  input  logic                      i_IssueWr_E,
  input  logic                      i_IssueLong_E,
  input  logic                      i_LongWrEn,
  input  logic [4:0]                i_LongWrAddr,
  output logic [NUM_RD*SEL_W-1:0]   o_FwdSel,
  output logic                      o_StoreFwd,
  output logic                      o_Stall,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]               o_StallCnt,
  output logic [3:0]                o_StallWhy,
`endif
  output logic [5:0]                o_PendCnt
);

  localparam int unsigned OldIdx = NUM_STG - 1;

  logic [31:1] pend_q, pend_d;
  logic [5:0]  pend_cnt_q, pend_cnt_d;
  logic [31:0] pend_vec;

  logic haz_a, haz_b, haz_c, haz_d;
  logic active, long_done, issue_fire;
  logic [NUM_RD*SEL_W-1:0] fwd_sel;

  // x0 is never pending; bit 0 of the lookup vector is tied low.
  assign pend_vec = {pend_q, 1'b0};

  assign active    = i_IssueValid_E && !i_Flush_E;
  assign long_done = i_LongWrEn && pend_vec[i_LongWrAddr];

  always_comb begin : fwd_comb
    logic [4:0]       rs;
    logic             hit;
    logic [SEL_W-1:0] sel;
    rs      = '0;
    hit     = 1'b0;
    sel     = '0;
    fwd_sel = '0;
    haz_a   = 1'b0;
    haz_b   = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      rs  = i_RsAddr_E[5*p +: 5];
      hit = 1'b0;
      sel = '0;
      if (i_RsUsed_E[p] && rs != 5'd0) begin
        // Youngest matching stage wins.
        for (int k = 0; k < NUM_STG; k++) begin
          if (!hit && i_StgRegWrEn[k] && i_StgRdAddr[5*k +: 5] == rs) begin
            hit = 1'b1;
            sel = SEL_W'(k + 1);
            if (!i_StgRdValid[k]) haz_a = 1'b1;
          end
        end
        if (!hit && i_LongWrEn && i_LongWrAddr == rs) sel = SEL_W'(NUM_STG + 1);
        if (pend_vec[rs] && !(i_LongWrEn && i_LongWrAddr == rs)) haz_b = 1'b1;
      end
      fwd_sel[SEL_W*p +: SEL_W] = sel;
    end
  end

  assign haz_c = i_IssueWr_E && (i_IssueRd_E != 5'd0) && pend_vec[i_IssueRd_E] &&
                 !(i_LongWrEn && i_LongWrAddr == i_IssueRd_E);
  // A completion in the same cycle frees a slot for the new long op.
  assign haz_d = i_IssueLong_E && (pend_cnt_q == 6'(MAX_OUT)) && !long_done;

  assign o_FwdSel = fwd_sel;
  assign o_Stall  = active && (haz_a || haz_b || haz_c || haz_d);

  assign issue_fire = active && !o_Stall && i_IssueLong_E && i_IssueWr_E &&
                      (i_IssueRd_E != 5'd0);

  assign o_StoreFwd = i_StgRegWrEn[OldIdx] && (i_StgRdAddr[5*OldIdx +: 5] != 5'd0) &&
                      (i_StgRdAddr[5*OldIdx +: 5] == i_RS2Addr_M);

  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < 32; r++) begin
      if (long_done && i_LongWrAddr == 5'(r)) pend_d[r] = 1'b0;
      if (issue_fire && i_IssueRd_E == 5'(r)) pend_d[r] = 1'b1;
    end
  end

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    unique case ({issue_fire, long_done})
      2'b10:   pend_cnt_d = pend_cnt_q + 6'd1;
      2'b01:   pend_cnt_d = pend_cnt_q - 6'd1;
      default: pend_cnt_d = pend_cnt_q;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign o_PendCnt = pend_cnt_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_Stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_StallCnt = stall_cnt_q;
  assign o_StallWhy = o_Stall ? {haz_d, haz_c, haz_b, haz_a} : 4'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_fwd_hazard_scoreboard;

  localparam int unsigned NUM_RD  = 2;
  localparam int unsigned NUM_STG = 2;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned SEL_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*5-1:0]      rs_addr_e;
  logic [NUM_STG*5-1:0]     stg_rd_addr;
  logic [NUM_RD-1:0]        t_used;
  logic [NUM_STG-1:0]       t_stg_wr, t_stg_valid;
  logic [4:0]               t_rs [NUM_RD];
  logic [4:0]               t_stg_rd [NUM_STG];
  logic [4:0]               t_rs2_m, t_issue_rd, t_long_addr;
  logic                     t_valid, t_flush, t_wr, t_long, t_long_en;
  logic [NUM_RD*SEL_W-1:0]  fwd_sel;
  logic                     store_fwd, stall;
  logic [5:0]               pend_cnt;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]              stall_cnt;
  logic [3:0]               stall_why;
`endif

  always #5 clk = ~clk;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rs_addr_e[5*p +: 5] = t_rs[p];
  end
  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    assign stg_rd_addr[5*k +: 5] = t_stg_rd[k];
  end

  fwd_hazard_scoreboard #(
    .NUM_RD (NUM_RD),
    .NUM_STG(NUM_STG),
    .MAX_OUT(MAX_OUT),
    .SEL_W  (SEL_W)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_RsAddr_E    (rs_addr_e),
    .i_RsUsed_E    (t_used),
    .i_StgRdAddr   (stg_rd_addr),
    .i_StgRegWrEn  (t_stg_wr),
    .i_StgRdValid  (t_stg_valid),
    .i_RS2Addr_M   (t_rs2_m),
    .i_IssueValid_E(t_valid),
    .i_Flush_E     (t_flush),
    .i_IssueRd_E   (t_issue_rd),
    .i_IssueWr_E   (t_wr),
    .i_IssueLong_E (t_long),
    .i_LongWrEn    (t_long_en),
    .i_LongWrAddr  (t_long_addr),
    .o_FwdSel      (fwd_sel),
    .o_StoreFwd    (store_fwd),
    .o_Stall       (stall),
`ifdef FWD_STALL_CNT_EN
    .o_StallCnt    (stall_cnt),
    .o_StallWhy    (stall_why),
`endif
    .o_PendCnt     (pend_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of pending registers; count is derived as its population.
  bit  m_pend [32];
  int  m_stall_cnt;
  int  e_sel [NUM_RD];
  bit  e_stall, e_store, e_issue, e_done;
  bit  e_a, e_b, e_c, e_d;

  function automatic int m_count();
    int n = 0;
    for (int r = 1; r < 32; r++) if (m_pend[r]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_stall_cnt = 0;
  endtask

  task automatic model_eval();
    bit long_hits;
    e_a = 0; e_b = 0; e_c = 0; e_d = 0;
    for (int p = 0; p < NUM_RD; p++) begin
      int  rs;
      int  found;
      rs = int'(t_rs[p]);
      e_sel[p] = 0;
      if (t_used[p] && rs != 0) begin
        found = -1;
        for (int k = NUM_STG - 1; k >= 0; k--)
          if (t_stg_wr[k] && int'(t_stg_rd[k]) == rs) found = k;
        long_hits = t_long_en && int'(t_long_addr) == rs;
        if (found >= 0) begin
          e_sel[p] = found + 1;
          if (!t_stg_valid[found]) e_a = 1;
        end else if (long_hits) begin
          e_sel[p] = NUM_STG + 1;
        end
        if (m_pend[rs] && !long_hits) e_b = 1;
      end
    end
    e_done = t_long_en && t_long_addr != 0 && m_pend[t_long_addr];
    e_c = t_wr && t_issue_rd != 0 && m_pend[t_issue_rd] &&
          !(t_long_en && t_long_addr == t_issue_rd);
    e_d = t_long && m_count() == MAX_OUT && !e_done;
    e_stall = t_valid && !t_flush && (e_a || e_b || e_c || e_d);
    e_issue = t_valid && !t_flush && !e_stall && t_long && t_wr && t_issue_rd != 0;
    e_store = t_stg_wr[NUM_STG-1] && t_stg_rd[NUM_STG-1] != 0 &&
              t_stg_rd[NUM_STG-1] == t_rs2_m;
  endtask

  task automatic eval_cycle();
    #1;
    model_eval();
    for (int p = 0; p < NUM_RD; p++)
      check_eq($sformatf("sel%0d", p), 32'(fwd_sel[SEL_W*p +: SEL_W]), 32'(e_sel[p]));
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("store_fwd", 32'(store_fwd), 32'(e_store));
    check_eq("pend_cnt", 32'(pend_cnt), 32'(m_count()));
`ifdef FWD_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, 32'(m_stall_cnt));
    check_eq("stall_why", 32'(stall_why),
             e_stall ? 32'({e_d, e_c, e_b, e_a}) : 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_done)  m_pend[t_long_addr] = 0;
    if (e_issue) m_pend[t_issue_rd]  = 1;
    if (e_stall) m_stall_cnt++;
    #1;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NUM_RD; p++) t_rs[p] = '0;
    for (int k = 0; k < NUM_STG; k++) t_stg_rd[k] = '0;
    t_used = '0; t_stg_wr = '0; t_stg_valid = '1;
    t_rs2_m = '0; t_issue_rd = '0; t_long_addr = '0;
    t_valid = 0; t_flush = 0; t_wr = 0; t_long = 0; t_long_en = 0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle_inputs();
    t_valid = 1; t_wr = 1; t_long = 1; t_issue_rd = rd;
    eval_cycle();
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #1;
    model_clear();
    check_eq("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    #1 rst_n = 1;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    rst_n = 0;
    #12 rst_n = 1;
    @(negedge clk);
    eval_cycle();
    check_eq("reset_cnt", 32'(pend_cnt), 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    tick();

    // x5 forwarded from Mem, then from the oldest stage.
    idle_inputs();
    t_valid = 1; t_used = 2'b01; t_rs[0] = 5'd5; t_stg_wr = 2'b01; t_stg_rd[0] = 5'd5;
    eval_cycle();
    check_eq("fwd_mem", 32'(fwd_sel[0 +: SEL_W]), 32'd1);
    check_eq("fwd_mem_stall", 32'(stall), 32'd0);
    tick();
    t_stg_wr = 2'b10; t_stg_rd[1] = 5'd5; t_stg_rd[0] = 5'd0; t_rs2_m = 5'd5;
    eval_cycle();
    check_eq("fwd_wb", 32'(fwd_sel[0 +: SEL_W]), 32'd2);
    check_eq("store_fwd_hit", 32'(store_fwd), 32'd1);
    tick();

    // Load-use on rs2 then resolved from the oldest stage.
    idle_inputs();
    t_valid = 1; t_used = 2'b10; t_rs[1] = 5'd7;
    t_stg_wr = 2'b01; t_stg_rd[0] = 5'd7; t_stg_valid = 2'b10;
    eval_cycle();
    check_eq("load_use_stall", 32'(stall), 32'd1);
    tick();
    t_stg_wr = 2'b10; t_stg_rd[1] = 5'd7; t_stg_rd[0] = 5'd0; t_stg_valid = 2'b11;
    eval_cycle();
    check_eq("load_wb_sel", 32'(fwd_sel[SEL_W +: SEL_W]), 32'd2);
    check_eq("load_wb_stall", 32'(stall), 32'd0);
    tick();

    // Long op x9: RAW stall until the long bus returns it.
    issue_long(5'd9);
    idle_inputs();
    t_valid = 1; t_used = 2'b01; t_rs[0] = 5'd9;
    eval_cycle();
    check_eq("long_cnt1", 32'(pend_cnt), 32'd1);
    check_eq("long_raw_stall", 32'(stall), 32'd1);
    tick();
    t_long_en = 1; t_long_addr = 5'd9;
    eval_cycle();
    check_eq("long_bus_sel", 32'(fwd_sel[0 +: SEL_W]), 32'd3);
    check_eq("long_bus_stall", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    eval_cycle();
    check_eq("long_cnt0", 32'(pend_cnt), 32'd0);
    tick();

    // Capacity: four outstanding, fifth stalls unless a completion frees a slot.
    for (int r = 1; r <= 4; r++) issue_long(5'(r));
    idle_inputs();
    t_valid = 1; t_wr = 1; t_long = 1; t_issue_rd = 5'd10;
    eval_cycle();
    check_eq("cap_cnt4", 32'(pend_cnt), 32'd4);
    check_eq("cap_stall", 32'(stall), 32'd1);
    t_long_en = 1; t_long_addr = 5'd2;
    eval_cycle();
    check_eq("cap_free_stall", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    eval_cycle();
    check_eq("cap_cnt_kept", 32'(pend_cnt), 32'd4);

    // Swap x1 for x12, then a short write to x12 is a WAW hazard unless flushed.
    t_valid = 1; t_wr = 1; t_long = 1; t_issue_rd = 5'd12; t_long_en = 1; t_long_addr = 5'd1;
    eval_cycle();
    tick();
    idle_inputs();
    t_valid = 1; t_wr = 1; t_issue_rd = 5'd12;
    eval_cycle();
    check_eq("waw_stall", 32'(stall), 32'd1);
    t_flush = 1;
    eval_cycle();
    check_eq("waw_flush", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    t_long_en = 1; t_long_addr = 5'd3;
    eval_cycle();
    tick();

    // Async reset with three outstanding, then x0 never forwards or stalls.
    idle_inputs();
    eval_cycle();
    check_eq("pre_rst_cnt", 32'(pend_cnt), 32'd3);
    apply_reset();
    t_valid = 1; t_used = 2'b11; t_stg_wr = 2'b11; t_stg_valid = 2'b00;
    t_long_en = 1;
    eval_cycle();
    check_eq("x0_sel", 32'(fwd_sel), 32'd0);
    check_eq("x0_stall", 32'(stall), 32'd0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < NUM_RD; p++) begin
        t_rs[p]   = 5'($urandom_range(0, 7));
        t_used[p] = $urandom_range(0, 3) != 0;
      end
      for (int k = 0; k < NUM_STG; k++) begin
        t_stg_rd[k]    = 5'($urandom_range(0, 7));
        t_stg_wr[k]    = $urandom_range(0, 1) != 0;
        t_stg_valid[k] = $urandom_range(0, 3) != 0;
      end
      t_rs2_m     = 5'($urandom_range(0, 7));
      t_valid     = $urandom_range(0, 4) != 0;
      t_flush     = $urandom_range(0, 9) == 0;
      t_issue_rd  = 5'($urandom_range(0, 7));
      t_wr        = $urandom_range(0, 4) != 0;
      t_long      = $urandom_range(0, 2) == 0;
      t_long_en   = $urandom_range(0, 2) == 0;
      t_long_addr = 5'($urandom_range(0, 7));
      eval_cycle();
      if (i == 1500) begin
        apply_reset();
        eval_cycle();
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
